// File: rtl/lab2_proc_int_div_pkg.sv
// Shared types and constants for the iterative integer divider.
// Optional early-out path is enabled by defining LAB2_PROC_INT_DIV_UNIT_EARLY_OUT_EN.
package lab2_proc_int_div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_fn_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_STEPS = 32;

  // Two's-complement magnitude when neg is set; 32'h80000000 maps to itself.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/lab2_proc_int_div_step.sv
// One combinational restoring-division step on 32-bit unsigned magnitudes.
// The quotient register doubles as the dividend shift register.
module lab2_proc_int_div_step (
  input  logic [31:0] rem_in,
  input  logic [31:0] quot_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic [31:0] quot_out
);

  logic [32:0] rem_sh;
  logic [33:0] diff;

  assign rem_sh = {rem_in, quot_in[31]};
  // One extra bit so the borrow is visible even for divisors near 2^32.
  assign diff   = {1'b0, rem_sh} - {2'b00, divisor};

  always_comb begin
    if (!diff[33]) begin
      rem_out  = diff[31:0];
      quot_out = {quot_in[30:0], 1'b1};
    end else begin
      rem_out  = rem_sh[31:0];
      quot_out = {quot_in[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/lab2_proc_int_div_unit.sv
// Iterative 32-bit DIV/DIVU/REM/REMU unit with val/rdy handshakes, one bit per cycle.
// Define LAB2_PROC_INT_DIV_UNIT_EARLY_OUT_EN to finish trivial cases (b==0, |a|<|b|) in one cycle.
module lab2_proc_int_div_unit
  import lab2_proc_int_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [1:0]  req_fn,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_data
);

  localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

  div_state_t  state_reg, state_next;
  logic [5:0]  count_reg, count_next;
  logic [31:0] rem_reg, rem_next;
  logic [31:0] quot_reg, quot_next;
  logic [31:0] divisor_reg, divisor_next;
  logic        is_rem_reg, is_rem_next;
  logic        neg_quot_reg, neg_quot_next;
  logic        neg_rem_reg, neg_rem_next;
  logic        b_zero_reg, b_zero_next;

  div_fn_t     fn;
  logic        is_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] step_rem, step_quot;
  logic [31:0] quot_res, rem_res;

  assign fn        = div_fn_t'(req_fn);
  assign is_signed = (fn == DIV) || (fn == REM);
  assign a_neg     = is_signed & req_a[31];
  assign b_neg     = is_signed & req_b[31];
  assign a_mag     = mag32(req_a, a_neg);
  assign b_mag     = mag32(req_b, b_neg);

  lab2_proc_int_div_step u_step (
    .rem_in   (rem_reg),
    .quot_in  (quot_reg),
    .divisor  (divisor_reg),
    .rem_out  (step_rem),
    .quot_out (step_quot)
  );

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    rem_next      = rem_reg;
    quot_next     = quot_reg;
    divisor_next  = divisor_reg;
    is_rem_next   = is_rem_reg;
    neg_quot_next = neg_quot_reg;
    neg_rem_next  = neg_rem_reg;
    b_zero_next   = b_zero_reg;
    req_rdy       = (state_reg == IDLE);
    resp_val      = (state_reg == DONE);

    case (state_reg)
      IDLE: begin
        if (req_val) begin
          state_next    = CALC;
          count_next    = 6'd0;
          rem_next      = 32'd0;
          quot_next     = a_mag;
          divisor_next  = b_mag;
          is_rem_next   = (fn == REM) || (fn == REMU);
          neg_quot_next = a_neg ^ b_neg;
          neg_rem_next  = a_neg;
          b_zero_next   = (req_b == 32'd0);
`ifdef LAB2_PROC_INT_DIV_UNIT_EARLY_OUT_EN
          // Quotient is 0 and remainder is |a|; b==0 quotient is forced at output.
          if ((req_b == 32'd0) || (a_mag < b_mag)) begin
            state_next = DONE;
            rem_next   = a_mag;
            quot_next  = 32'd0;
          end
`endif
        end
      end
      CALC: begin
        rem_next   = step_rem;
        quot_next  = step_quot;
        count_next = count_reg + 6'd1;
        if (count_reg == LAST_STEP) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (resp_rdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      count_reg    <= 6'd0;
      rem_reg      <= 32'd0;
      quot_reg     <= 32'd0;
      divisor_reg  <= 32'd0;
      is_rem_reg   <= 1'b0;
      neg_quot_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      b_zero_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      rem_reg      <= rem_next;
      quot_reg     <= quot_next;
      divisor_reg  <= divisor_next;
      is_rem_reg   <= is_rem_next;
      neg_quot_reg <= neg_quot_next;
      neg_rem_reg  <= neg_rem_next;
      b_zero_reg   <= b_zero_next;
    end
  end

  // Divide-by-zero quotient is all ones regardless of operand signs.
  assign quot_res  = b_zero_reg ? 32'hFFFF_FFFF : (neg_quot_reg ? (~quot_reg + 32'd1) : quot_reg);
  assign rem_res   = neg_rem_reg ? (~rem_reg + 32'd1) : rem_reg;
  assign resp_data = resp_val ? (is_rem_reg ? rem_res : quot_res) : 32'd0;

endmodule

// File: tb/tb_lab2_proc_int_div_unit.sv
// Directed bench for lab2_proc_int_div_unit: latency, results, stall, async reset.
// Early-out expectations follow LAB2_PROC_INT_DIV_UNIT_EARLY_OUT_EN.
module tb_lab2_proc_int_div_unit;

  localparam logic [1:0] F_DIV = 2'd0, F_DIVU = 2'd1, F_REM = 2'd2, F_REMU = 2'd3;
  localparam int FULL_LAT = 33;
`ifdef LAB2_PROC_INT_DIV_UNIT_EARLY_OUT_EN
  localparam int SHORT_LAT = 1;
`else
  localparam int SHORT_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_val = 1'b0;
  logic        req_rdy;
  logic [1:0]  req_fn = 2'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        resp_val;
  logic        resp_rdy = 1'b1;
  logic [31:0] resp_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lab2_proc_int_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_fn    (req_fn),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_data (resp_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for the response and consume it immediately.
  task automatic run_op(input string tag, input logic [1:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    check({tag, " req_rdy"}, 32'(req_rdy), 32'd1);
    req_val  = 1'b1;
    req_fn   = fn;
    req_a    = a;
    req_b    = b;
    resp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    req_a   = 32'hDEAD_BEEF;
    req_b   = 32'h1234_5678;
    n = 1;
    while (!resp_val && n < 100) begin
      check({tag, " idle_data"}, resp_data, 32'd0);
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " data"}, resp_data, exp);
    $display("op %s fn=%0d a=%h b=%h -> %h after %0d cycles", tag, fn, a, b, resp_data, n);
    @(negedge clk);
    check({tag, " resp_val_clr"}, 32'(resp_val), 32'd0);
  endtask

  initial begin : main
    int n;
    // Reset state while reset is held low.
    #3;
    check("rst req_rdy", 32'(req_rdy), 32'd1);
    check("rst resp_val", 32'(resp_val), 32'd0);
    check("rst resp_data", resp_data, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT);
    run_op("remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2, FULL_LAT);
    run_op("div_m100_7", F_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, FULL_LAT);
    run_op("rem_m100_7", F_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, FULL_LAT);
    run_op("div_100_m7", F_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, FULL_LAT);
    run_op("rem_100_m7", F_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, FULL_LAT);
    run_op("divu_max_1", F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, FULL_LAT);
    run_op("divu_max_3", F_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, FULL_LAT);
    run_op("div_5_0", F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SHORT_LAT);
    run_op("remu_5_0", F_REMU, 32'd5, 32'd0, 32'd5, SHORT_LAT);
    run_op("rem_m5_0", F_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SHORT_LAT);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FULL_LAT);
    run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, FULL_LAT);
    run_op("divu_3_10", F_DIVU, 32'd3, 32'd10, 32'd0, SHORT_LAT);
    run_op("remu_3_10", F_REMU, 32'd3, 32'd10, 32'd3, SHORT_LAT);
    run_op("divu_30_10", F_DIVU, 32'd30, 32'd10, 32'd3, FULL_LAT);

    // Stall in DONE with a competing request present.
    @(negedge clk);
    req_val  = 1'b1;
    req_fn   = F_DIVU;
    req_a    = 32'd1000;
    req_b    = 32'd10;
    resp_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_a = 32'd77;
    req_b = 32'd7;
    n = 1;
    while (!resp_val && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall latency", 32'(n), 32'(FULL_LAT));
    for (int i = 0; i < 10; i++) begin
      check("stall resp_val", 32'(resp_val), 32'd1);
      check("stall data", resp_data, 32'd100);
      check("stall req_rdy", 32'(req_rdy), 32'd0);
      @(negedge clk);
    end
    $display("stall held 10 cycles data=%h", resp_data);
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    check("stall resp_val_clr", 32'(resp_val), 32'd0);
    check("stall back_idle", 32'(req_rdy), 32'd1);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    req_val = 1'b1;
    req_fn  = F_DIVU;
    req_a   = 32'd1000;
    req_b   = 32'd7;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    repeat (15) @(negedge clk);
    check("mid req_rdy", 32'(req_rdy), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("arst req_rdy", 32'(req_rdy), 32'd1);
    check("arst resp_val", 32'(resp_val), 32'd0);
    check("arst resp_data", resp_data, 32'd0);
    $display("async reset applied mid-calc");
    @(negedge clk);
    reset = 1'b1;
    run_op("post_rst_divu_9_3", F_DIVU, 32'd9, 32'd3, 32'd3, FULL_LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
